// File: rtl/pim_job_sequencer.sv
// rtl/pim_job_sequencer.sv - replays one PIM MAC job (zero point, load, exec, wait, readout) on the peripheral bus
// Optional zero-point write at job start is enabled by defining PIM_SEQ_ZERO_POINT_EN.
module pim_job_sequencer #(
  parameter logic [31:0] ADDR_IDLE   = 32'h0000_0000,
  parameter logic [31:0] ADDR_ZP     = 32'h0000_0010,
  parameter logic [31:0] ADDR_INPUT  = 32'h0000_0020,
  parameter logic [31:0] ADDR_EXEC   = 32'h0000_0030,
  parameter logic [31:0] ADDR_READ   = 32'h0000_0040,
  parameter int unsigned EXEC_CYCLES = 16,
  parameter int unsigned OUT_WORDS   = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [6:0]  cmd_row_addr7_i,
  input  logic [8:0]  cmd_col_addr9_i,
  input  logic [4:0]  cmd_words_i,
  input  logic [31:0] cmd_zp_i,
  input  logic        wdata_valid_i,
  output logic        wdata_ready_o,
  input  logic [31:0] wdata_i,
  input  logic        abort_i,
  output logic [31:0] address_o,
  output logic [31:0] data_o,
  input  logic [31:0] peri_rdata_i,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ZP    = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_READ  = 3'd5;
  localparam logic [2:0] S_DRAIN = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam logic [7:0] WAIT_LAST = 8'(EXEC_CYCLES - 1);
  localparam logic [4:0] IDX_LAST  = 5'(OUT_WORDS - 1);

  logic [2:0]  state_q, state_d;
  logic [6:0]  row_q, row_d;
  logic [8:0]  col_q, col_d;
  logic [4:0]  wcnt_q, wcnt_d;
  logic [7:0]  wait_q, wait_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        addr_rd_q, addr_rd_d;
  logic        rd_pend_q, rd_pend_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic [4:0]  words_clamped;

`ifdef PIM_SEQ_ZERO_POINT_EN
  logic [31:0] zp_q, zp_d;
`else
  logic        unused_zp;
  assign unused_zp = ^cmd_zp_i;
`endif

  assign words_clamped = (cmd_words_i > 5'd16) ? 5'd16 : cmd_words_i;

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    wcnt_d        = wcnt_q;
    wait_d        = wait_q;
    idx_d         = idx_q;
    addr_d        = ADDR_IDLE;
    data_d        = 32'd0;
    addr_rd_d     = 1'b0;
    // Read pipeline: bus address, then peripheral data, then registered output.
    rd_pend_d     = addr_rd_q;
    rdata_valid_d = rd_pend_q;
    rdata_d       = rd_pend_q ? peri_rdata_i : rdata_q;
`ifdef PIM_SEQ_ZERO_POINT_EN
    zp_d          = zp_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          row_d  = cmd_row_addr7_i;
          col_d  = cmd_col_addr9_i;
          wcnt_d = words_clamped;
`ifdef PIM_SEQ_ZERO_POINT_EN
          zp_d    = cmd_zp_i;
          state_d = S_ZP;
`else
          state_d = (words_clamped == 5'd0) ? S_EXEC : S_LOAD;
`endif
        end
      end
`ifdef PIM_SEQ_ZERO_POINT_EN
      S_ZP: begin
        addr_d  = ADDR_ZP;
        data_d  = zp_q;
        state_d = (wcnt_q == 5'd0) ? S_EXEC : S_LOAD;
      end
`endif
      S_LOAD: begin
        if (wdata_valid_i) begin
          addr_d = ADDR_INPUT;
          data_d = wdata_i;
          if (wcnt_q != 5'd0) wcnt_d = wcnt_q - 5'd1;
          if (wcnt_q <= 5'd1) state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        addr_d  = ADDR_EXEC;
        data_d  = {16'b0, row_q, col_q};
        wait_d  = WAIT_LAST;
        idx_d   = 5'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == 8'd0) state_d = S_READ;
        else                wait_d  = wait_q - 8'd1;
      end
      S_READ: begin
        addr_d    = ADDR_READ | {27'b0, idx_q};
        addr_rd_d = 1'b1;
        if (idx_q == IDX_LAST) state_d = S_DRAIN;
        else                   idx_d   = idx_q + 5'd1;
      end
      S_DRAIN: begin
        if (rdata_valid_q && !rd_pend_q && !addr_rd_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort_i && state_q != S_IDLE) begin
      state_d       = S_IDLE;
      addr_d        = ADDR_IDLE;
      data_d        = 32'd0;
      addr_rd_d     = 1'b0;
      rd_pend_d     = 1'b0;
      rdata_valid_d = 1'b0;
      wcnt_d        = 5'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      row_q         <= 7'd0;
      col_q         <= 9'd0;
      wcnt_q        <= 5'd0;
      wait_q        <= 8'd0;
      idx_q         <= 5'd0;
      addr_q        <= ADDR_IDLE;
      data_q        <= 32'd0;
      addr_rd_q     <= 1'b0;
      rd_pend_q     <= 1'b0;
      rdata_q       <= 32'd0;
      rdata_valid_q <= 1'b0;
`ifdef PIM_SEQ_ZERO_POINT_EN
      zp_q          <= 32'd0;
`endif
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      wcnt_q        <= wcnt_d;
      wait_q        <= wait_d;
      idx_q         <= idx_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      addr_rd_q     <= addr_rd_d;
      rd_pend_q     <= rd_pend_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
`ifdef PIM_SEQ_ZERO_POINT_EN
      zp_q          <= zp_d;
`endif
    end
  end

  assign cmd_ready_o   = (state_q == S_IDLE);
  assign busy_o        = !cmd_ready_o;
  assign wdata_ready_o = (state_q == S_LOAD);
  assign done_o        = (state_q == S_DONE) && !abort_i;
  assign address_o     = addr_q;
  assign data_o        = data_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rdata_valid_q;

endmodule

// File: tb/tb_pim_job_sequencer.sv
// tb/tb_pim_job_sequencer.sv - directed self-checking bench for pim_job_sequencer
// Honours PIM_SEQ_ZERO_POINT_EN when the design is built with it.
module tb_pim_job_sequencer;
  localparam int EXC = 4;
  localparam int OW  = 4;
`ifdef PIM_SEQ_ZERO_POINT_EN
  localparam bit ZP_EN = 1'b1;
`else
  localparam bit ZP_EN = 1'b0;
`endif
  localparam logic [31:0] ZP_VAL = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [6:0]  cmd_row_addr7_i = '0;
  logic [8:0]  cmd_col_addr9_i = '0;
  logic [4:0]  cmd_words_i = '0;
  logic [31:0] cmd_zp_i = ZP_VAL;
  logic        wdata_valid_i = 1'b0;
  logic        wdata_ready_o;
  logic [31:0] wdata_i = '0;
  logic        abort_i = 1'b0;
  logic [31:0] address_o, data_o, rdata_o;
  logic [31:0] peri_rdata_i = '0;
  logic        rdata_valid_o, busy_o, done_o;

  pim_job_sequencer #(.EXEC_CYCLES(EXC), .OUT_WORDS(OW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_row_addr7_i(cmd_row_addr7_i), .cmd_col_addr9_i(cmd_col_addr9_i),
    .cmd_words_i(cmd_words_i), .cmd_zp_i(cmd_zp_i),
    .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i),
    .abort_i(abort_i), .address_o(address_o), .data_o(data_o),
    .peri_rdata_i(peri_rdata_i), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  // Synchronous-read peripheral: returns the address presented last cycle.
  always @(posedge clk) peri_rdata_i <= address_o;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          c;
  } ev_t;

  int   cyc = 0;
  ev_t  bus_q[$];
  ev_t  rd_q[$];
  int   hs_cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  logic prev_done = 1'b0;
  logic ready_after_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_ni) begin
      if (cmd_valid_i && cmd_ready_o) hs_cyc <= cyc;
      if (address_o != 32'd0 || data_o != 32'd0) bus_q.push_back('{address_o, data_o, cyc});
      if (rdata_valid_o) rd_q.push_back('{rdata_o, 32'd0, cyc});
      if (prev_done) ready_after_done <= cmd_ready_o;
      if (done_o) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      prev_done <= done_o;
    end
  end

  int passed = 0;
  int total  = 0;
  int bus_b, rd_b, done_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!cmd_ready_o && k < 300) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic start_job(input logic [4:0] n, input logic [6:0] row, input logic [8:0] col,
                           input int stall, input int n_send);
    wait_idle();
    bus_b  = bus_q.size();
    rd_b   = rd_q.size();
    done_b = done_cnt;
    @(posedge clk); #1;
    cmd_valid_i = 1'b1;
    cmd_words_i = n;
    cmd_row_addr7_i = row;
    cmd_col_addr9_i = col;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    for (int i = 0; i < n_send; i++) begin
      int k;
      k = 0;
      wdata_i = 32'hAAAA_0000 + 32'(i + 1);
      wdata_valid_i = 1'b1;
      @(negedge clk);
      while (!wdata_ready_o && k < 50) begin
        @(negedge clk);
        k++;
      end
      @(posedge clk); #1;
      if (stall > 0 && i < n_send - 1) begin
        wdata_valid_i = 1'b0;
        repeat (stall) begin
          @(posedge clk); #1;
        end
      end
    end
    wdata_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!(done_cnt > done_b && cmd_ready_o) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({tag, " finished"}, (k < 300) ? 32'd1 : 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic verify(input string tag, input int n_eff, input logic [6:0] row,
                        input logic [8:0] col, input int stall);
    ev_t exp[$];
    int  nb, nr, ie, ir;
    if (ZP_EN) exp.push_back('{32'h10, ZP_VAL, 0});
    for (int i = 0; i < n_eff; i++) exp.push_back('{32'h20, 32'hAAAA_0000 + 32'(i + 1), 0});
    exp.push_back('{32'h30, {16'b0, row, col}, 0});
    for (int i = 0; i < OW; i++) exp.push_back('{32'h40 + 32'(i), 32'd0, 0});
    ie = (ZP_EN ? 1 : 0) + n_eff;
    ir = ie + 1;
    nb = bus_q.size() - bus_b;
    nr = rd_q.size() - rd_b;
    check({tag, " bus_count"}, 32'(nb), 32'(exp.size()));
    if (nb == exp.size()) begin
      for (int i = 0; i < nb; i++) begin
        check($sformatf("%s addr[%0d]", tag, i), bus_q[bus_b + i].a, exp[i].a);
        check($sformatf("%s data[%0d]", tag, i), bus_q[bus_b + i].d, exp[i].d);
      end
      check({tag, " first_access_latency"}, 32'(bus_q[bus_b].c - hs_cyc), 32'd2);
      for (int j = (ZP_EN ? 2 : 1); j < ie; j++)
        check($sformatf("%s load_gap[%0d]", tag, j),
              32'(bus_q[bus_b + j].c - bus_q[bus_b + j - 1].c), 32'(1 + stall));
      if (ie > 0)
        check({tag, " exec_follows"}, 32'(bus_q[bus_b + ie].c - bus_q[bus_b + ie - 1].c), 32'd1);
      check({tag, " wait_len"}, 32'(bus_q[bus_b + ir].c - bus_q[bus_b + ie].c), 32'(EXC + 1));
      check({tag, " rd_count"}, 32'(nr), 32'(OW));
      if (nr == OW) begin
        for (int j = 0; j < OW; j++) begin
          check($sformatf("%s rdata[%0d]", tag, j), rd_q[rd_b + j].a, 32'h40 + 32'(j));
          check($sformatf("%s rdata_lat[%0d]", tag, j),
                32'(rd_q[rd_b + j].c - bus_q[bus_b + ir + j].c), 32'd2);
        end
        check({tag, " done_after_last_rdata"}, 32'(done_cyc - rd_q[rd_b + OW - 1].c), 32'd1);
      end
    end
    check({tag, " done_pulses"}, 32'(done_cnt - done_b), 32'd1);
    check({tag, " ready_after_done"}, 32'(ready_after_done), 32'd1);
  endtask

  task automatic abort_test(input string tag, input int delay, input bit in_read);
    int rb, bb, db;
    start_job(5'd0, 7'h22, 9'h044, 0, 0);
    repeat (delay + (ZP_EN ? 1 : 0)) begin
      @(posedge clk); #1;
    end
    abort_i = 1'b1;
    @(negedge clk);
    check({tag, " busy_before"}, 32'(busy_o), 32'd1);
    if (in_read) check({tag, " rvalid_before"}, 32'(rdata_valid_o), 32'd1);
    @(posedge clk); #1;
    abort_i = 1'b0;
    @(negedge clk);
    check({tag, " bus_addr_idle"}, address_o, 32'd0);
    check({tag, " bus_data_idle"}, data_o, 32'd0);
    check({tag, " rvalid_flushed"}, 32'(rdata_valid_o), 32'd0);
    check({tag, " cmd_ready"}, 32'(cmd_ready_o), 32'd1);
    rb = rd_q.size();
    bb = bus_q.size();
    db = done_cnt;
    repeat (12) @(negedge clk);
    check({tag, " no_more_rdata"}, 32'(rd_q.size() - rb), 32'd0);
    check({tag, " no_more_bus"}, 32'(bus_q.size() - bb), 32'd0);
    check({tag, " no_done"}, 32'(done_cnt - db), 32'd0);
    check({tag, " no_done_total"}, 32'(done_cnt - done_b), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset address_o", address_o, 32'd0);
    check("reset data_o", data_o, 32'd0);
    check("reset cmd_ready_o", 32'(cmd_ready_o), 32'd1);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    check("post_reset rdata_o", rdata_o, 32'd0);
    check("post_reset rdata_valid_o", 32'(rdata_valid_o), 32'd0);
    check("post_reset done_o", 32'(done_o), 32'd0);
    check("post_reset wdata_ready_o", 32'(wdata_ready_o), 32'd0);
    check("post_reset busy_o", 32'(busy_o), 32'd0);

    start_job(5'd2, 7'h05, 9'h1A3, 0, 2);
    wait_done("basic");
    verify("basic", 2, 7'h05, 9'h1A3, 0);

    start_job(5'd2, 7'h11, 9'h0F0, 3, 2);
    wait_done("stall");
    verify("stall", 2, 7'h11, 9'h0F0, 3);

    start_job(5'd0, 7'h7F, 9'h1FF, 0, 0);
    wait_done("zero_words");
    verify("zero_words", 0, 7'h7F, 9'h1FF, 0);

    start_job(5'd31, 7'h00, 9'h001, 0, 16);
    wait_done("clamp");
    verify("clamp", 16, 7'h00, 9'h001, 0);

    abort_test("abort_wait", 2, 1'b0);
    abort_test("abort_read", 8, 1'b1);

    start_job(5'd2, 7'h05, 9'h1A3, 0, 1);
    check("midload bus_addr", address_o, ZP_EN ? 32'h10 : 32'h20);
    check("midload busy", 32'(busy_o), 32'd1);
    #1 rst_ni = 1'b0;
    #1;
    check("midload_reset address_o", address_o, 32'd0);
    check("midload_reset data_o", data_o, 32'd0);
    check("midload_reset cmd_ready_o", 32'(cmd_ready_o), 32'd1);
    check("midload_reset rdata_valid_o", 32'(rdata_valid_o), 32'd0);
    check("midload_reset wdata_ready_o", 32'(wdata_ready_o), 32'd0);
    @(posedge clk); #1 rst_ni = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
